seconds_seg7_display: RTL and testbench

Two-digit seven-segment display driver for the seconds/minutes counters. Splits a 6-bit binary count (0–63) into decimal tens and units digits and converts each to an active-low seven-segment pattern. Outputs are registered and drive the board's HEX displays directly. It sits downstream of the counter blocks and replaces the combinational split/decode pair.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_lut.sv | 25 ++
 rtl/seconds_seg7_display.sv | 54 +++++
 tb/tb_seconds_seg7_display.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low patterns, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;

endpackage

// File: rtl/seg7_lut.sv
// Combinational BCD digit to active-low seven-segment pattern; codes 10-15 blank.
module seg7_lut (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);
  import seg7_pkg::*;

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seconds_seg7_display.sv
// Two-digit registered seven-segment driver for a 0-63 count.
// Define LEADING_ZERO_BLANK_EN to blank the tens display when the tens digit is 0.
module seconds_seg7_display (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [5:0] value,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] S1,
  output logic [6:0] S2
);
  import seg7_pkg::*;

  logic [3:0] w_tens;
  logic [3:0] w_units;
  logic [6:0] w_seg_tens;
  logic [6:0] w_seg_units;
  logic [6:0] w_s1_next;

  assign w_tens  = 4'(value / 6'd10);
  assign w_units = 4'(value % 6'd10);

  seg7_lut u_lut_tens (
    .i_digit (w_tens),
    .o_seg   (w_seg_tens)
  );

  seg7_lut u_lut_units (
    .i_digit (w_units),
    .o_seg   (w_seg_units)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_s1_next = (w_tens == 4'd0) ? SEG_BLANK : w_seg_tens;
`else
  assign w_s1_next = w_seg_tens;
`endif

  // All four outputs share one register stage so the displays never skew.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
      S1    <= SEG_BLANK;
      S2    <= SEG_BLANK;
    end else begin
      tens  <= w_tens;
      units <= w_units;
      S1    <= w_s1_next;
      S2    <= w_seg_units;
    end
  end

endmodule

// File: tb/tb_seconds_seg7_display.sv
// Randomized self-checking bench for seconds_seg7_display against a divide/modulo model.
module tb_seconds_seg7_display;

  logic       clk_50 = 1'b0;
  logic       rst;
  logic [5:0] value;
  logic [3:0] tens;
  logic [3:0] units;
  logic [6:0] S1;
  logic [6:0] S2;

  int total = 0;
  int bad   = 0;

  seconds_seg7_display dut (
    .clk_50 (clk_50),
    .rst    (rst),
    .value  (value),
    .tens   (tens),
    .units  (units),
    .S1     (S1),
    .S2     (S2)
  );

  always #10 clk_50 = ~clk_50;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] pat_tens(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 0) return 7'h7F;
`endif
    return pat(d);
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    value = 6'd37;
    #1;
    total += 4;
    if (tens !== 4'd0)   begin bad++; $display("FAIL reset_tens got=%0d want=0", tens); end
    if (units !== 4'd0)  begin bad++; $display("FAIL reset_units got=%0d want=0", units); end
    if (S1 !== 7'h7F)    begin bad++; $display("FAIL reset_S1 got=%h want=7f", S1); end
    if (S2 !== 7'h7F)    begin bad++; $display("FAIL reset_S2 got=%h want=7f", S2); end
    @(negedge clk_50);
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    int vals[3] = '{0, 59, 63};
    foreach (vals[k]) begin
      @(negedge clk_50);
      value = 6'(vals[k]);
      @(posedge clk_50);
      #1;
      total += 4;
      if (tens !== 4'(vals[k] / 10))
        begin bad++; $display("FAIL fixed_tens v=%0d got=%0d want=%0d", vals[k], tens, vals[k] / 10); end
      if (units !== 4'(vals[k] % 10))
        begin bad++; $display("FAIL fixed_units v=%0d got=%0d want=%0d", vals[k], units, vals[k] % 10); end
      if (S1 !== pat_tens(vals[k] / 10))
        begin bad++; $display("FAIL fixed_S1 v=%0d got=%h want=%h", vals[k], S1, pat_tens(vals[k] / 10)); end
      if (S2 !== pat(vals[k] % 10))
        begin bad++; $display("FAIL fixed_S2 v=%0d got=%h want=%h", vals[k], S2, pat(vals[k] % 10)); end
    end
  endtask

  // Checks that each output follows the value presented before the edge, not the one after.
  task automatic test_sweep();
    for (int v = 0; v < 64; v++) begin
      @(negedge clk_50);
      value = 6'(v);
      @(posedge clk_50);
      #1;
      value = 6'((v + 17) % 64);
      #1;
      total += 4;
      if (tens !== 4'(v / 10))
        begin bad++; $display("FAIL sweep_tens v=%0d got=%0d want=%0d", v, tens, v / 10); end
      if (units !== 4'(v % 10))
        begin bad++; $display("FAIL sweep_units v=%0d got=%0d want=%0d", v, units, v % 10); end
      if (S1 !== pat_tens(v / 10))
        begin bad++; $display("FAIL sweep_S1 v=%0d got=%h want=%h", v, S1, pat_tens(v / 10)); end
      if (S2 !== pat(v % 10))
        begin bad++; $display("FAIL sweep_S2 v=%0d got=%h want=%h", v, S2, pat(v % 10)); end
    end
  endtask

  task automatic test_rollover();
    @(negedge clk_50);
    value = 6'd59;
    @(posedge clk_50);
    #1;
    value = 6'd0;
    #1;
    total += 2;
    if (tens !== 4'd5 || units !== 4'd9)
      begin bad++; $display("FAIL roll_hold got=%0d/%0d want=5/9", tens, units); end
    if (S1 !== pat_tens(5) || S2 !== pat(9))
      begin bad++; $display("FAIL roll_hold_seg got=%h/%h want=%h/%h", S1, S2, pat_tens(5), pat(9)); end
    @(posedge clk_50);
    #1;
    total += 2;
    if (tens !== 4'd0 || units !== 4'd0)
      begin bad++; $display("FAIL roll_zero got=%0d/%0d want=0/0", tens, units); end
    if (S1 !== pat_tens(0) || S2 !== pat(0))
      begin bad++; $display("FAIL roll_zero_seg got=%h/%h want=%h/%h", S1, S2, pat_tens(0), pat(0)); end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int exp_v;
    @(negedge clk_50);
    for (int i = 0; i < 200; i++) begin
      value = 6'($urandom_range(63));
      q.push_back(int'(value));
      @(posedge clk_50);
      #1;
      exp_v = q.pop_front();
      total += 2;
      if (tens !== 4'(exp_v / 10) || units !== 4'(exp_v % 10))
        begin bad++; $display("FAIL rand_digits v=%0d got=%0d/%0d want=%0d/%0d", exp_v, tens, units, exp_v / 10, exp_v % 10); end
      if (S1 !== pat_tens(exp_v / 10) || S2 !== pat(exp_v % 10))
        begin bad++; $display("FAIL rand_seg v=%0d got=%h/%h want=%h/%h", exp_v, S1, S2, pat_tens(exp_v / 10), pat(exp_v % 10)); end
      @(negedge clk_50);
    end
  endtask

  task automatic test_reset_mid();
    int v;
    for (int r = 0; r < 4; r++) begin
      v = 10 + int'($urandom_range(53));
      @(negedge clk_50);
      value = 6'(v);
      @(posedge clk_50);
      #3;
      rst = 1'b1;
      #1;
      total += 2;
      if (tens !== 4'd0 || units !== 4'd0)
        begin bad++; $display("FAIL midrst_digits got=%0d/%0d want=0/0", tens, units); end
      if (S1 !== 7'h7F || S2 !== 7'h7F)
        begin bad++; $display("FAIL midrst_seg got=%h/%h want=7f/7f", S1, S2); end
      v = int'($urandom_range(63));
      value = 6'(v);
      #2;
      rst = 1'b0;
      @(posedge clk_50);
      #1;
      total += 2;
      if (tens !== 4'(v / 10) || units !== 4'(v % 10))
        begin bad++; $display("FAIL postrst_digits v=%0d got=%0d/%0d want=%0d/%0d", v, tens, units, v / 10, v % 10); end
      if (S1 !== pat_tens(v / 10) || S2 !== pat(v % 10))
        begin bad++; $display("FAIL postrst_seg v=%0d got=%h/%h want=%h/%h", v, S1, S2, pat_tens(v / 10), pat(v % 10)); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_sweep();
    test_rollover();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
